// File: rtl/xor_pkg.sv
// Shared definitions for the XOR datapath arbiter: datapath width, FSM state and requester ID types.
package xor_pkg;

  localparam int unsigned XOR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/xor4bit.sv
// Shared 4-bit bitwise XOR datapath; exactly one instance exists per arbiter.
module xor4bit
  import xor_pkg::*;
(
  input  logic [XOR_W-1:0] a,
  input  logic [XOR_W-1:0] b,
  output logic [XOR_W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor4_share_arb.sv
// Two-requester arbiter/sequencer around one shared xor4bit; round-robin by default,
// fixed priority to requester 0 when XOR4_SHARE_ARB_FIXED_PRIO_EN is defined.
module xor4_share_arb
  import xor_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] xor_y;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             load_rsp;
  logic             retire;
  req_id_t          winner;

`ifdef XOR4_SHARE_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic rr_ptr;

  // rr_ptr names the requester that wins the next tie
  assign grant1 = req1_valid & (~req0_valid | rr_ptr);
  assign grant0 = req0_valid & ~grant1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant1;
    end
  end
`endif

  assign winner     = req_id_t'(grant1);
  assign req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;
  assign busy       = (state_q != IDLE);

  xor4bit u_xor (
    .a (op_a),
    .b (op_b),
    .y (xor_y)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_rsp = 1'b0;
    retire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        load_rsp = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands and owner ID load on accept only; response fields stay put through RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      op_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a   <= grant1 ? req1_a : req0_a;
        op_b   <= grant1 ? req1_b : req0_b;
        rsp_id <= winner;
      end
      if (load_rsp) begin
        rsp_data  <= xor_y;
        rsp_valid <= 1'b1;
      end
      if (retire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xor4_share_arb.sv
// Randomized bench for xor4_share_arb against a transaction-timing reference model;
// honours XOR4_SHARE_ARB_FIXED_PRIO_EN for the expected grant rule.
module tb_xor4_share_arb;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_ready;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready;
  logic       busy;
  logic [7:0] op_count;

  xor4_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  pair_t q0[$];
  pair_t q1[$];
  int    rmode  = 1;   // 0: rsp_ready low, 1: high, 2: random
  bit    jitter = 1'b0;

  // Reference model: transaction view of the block
  bit         m_free = 1'b1;
  bit         m_ptr  = 1'b0;
  int         m_cnt  = 0;
  bit         m_have = 1'b0;
  int         m_from = 0;
  logic [3:0] m_data = 4'h0;
  bit         m_id   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit pick(input bit v0, input bit v1, input bit ptr);
`ifdef XOR4_SHARE_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return ptr;
    return v1;
`endif
  endfunction

  task automatic step();
    bit    v0;
    bit    v1;
    bit    w;
    bit    acc;
    bit    vis;
    pair_t p;
    v0 = (q0.size() > 0) && (m_free || !jitter || ($urandom_range(1, 0) == 1));
    v1 = (q1.size() > 0) && (m_free || !jitter || ($urandom_range(1, 0) == 1));
    req0_valid = v0;
    req1_valid = v1;
    req0_a = v0 ? q0[0].a : 4'($urandom);
    req0_b = v0 ? q0[0].b : 4'($urandom);
    req1_a = v1 ? q1[0].a : 4'($urandom);
    req1_b = v1 ? q1[0].b : 4'($urandom);
    rsp_ready = (rmode == 2) ? 1'($urandom_range(1, 0)) : (rmode == 1);
    #1;
    w   = pick(v0, v1, m_ptr);
    acc = rst_n && m_free && (v0 || v1);
    vis = m_have && (cyc >= m_from);
    check("req0_ready", 32'(req0_ready), 32'(acc && !w));
    check("req1_ready", 32'(req1_ready), 32'(acc && w));
    check("busy", 32'(busy), 32'(!m_free));
    check("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) begin
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (!rst_n) begin
      m_free = 1'b1;
      m_ptr  = 1'b0;
      m_cnt  = 0;
      m_have = 1'b0;
    end else if (acc) begin
      p      = w ? q1.pop_front() : q0.pop_front();
      m_data = p.a ^ p.b;
      m_id   = w;
      m_have = 1'b1;
      m_from = cyc + 2;
      m_free = 1'b0;
      m_ptr  = ~w;
    end else if (vis && rsp_ready) begin
      m_have = 1'b0;
      m_free = 1'b1;
      m_cnt  = (m_cnt + 1) % 256;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int max_steps);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_have) && n < max_steps) begin
      step();
      n++;
    end
    if (q0.size() > 0 || q1.size() > 0 || m_have)
      check("drain_timeout", 32'(n), 32'(max_steps + 1));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst_n = 1'b1;
  endtask

  task automatic push(input int id, input logic [3:0] a, input logic [3:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    if (id == 0) q0.push_back(p);
    else q1.push_back(p);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 4'h0;
    req0_b = 4'h0;
    req1_a = 4'h0;
    req1_b = 4'h0;
    rsp_ready = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset(2);
    check("reset_rsp_data", 32'(rsp_data), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);

    // Single request from requester 0
    push(0, 4'hA, 4'h5);
    drain(20);
    check("single_count", 32'(op_count), 32'd1);

    // Both requesting continuously, consumer always ready
    for (int i = 0; i < 4; i++) begin
      push(0, 4'h3, 4'h1);
      push(1, 4'hC, 4'hC);
    end
    drain(40);

    // Consumer stalls while a response is held
    push(0, 4'h6, 4'h9);
    push(1, 4'h7, 4'h1);
    rmode = 0;
    for (int i = 0; i < 8; i++) step();
    rmode = 1;
    drain(20);

    // Reset in the middle of an operation
    push(1, 4'h2, 4'h4);
    push(0, 4'h1, 4'h1);
    push(0, 4'h8, 4'h1);
    step();
    do_reset(1);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_count", 32'(op_count), 32'h0);
    drain(40);

    // Counter wrap after 256 completions
    do_reset(1);
    for (int i = 0; i < 256; i++) push(0, 4'($urandom), 4'($urandom));
    drain(256 * 3 + 20);
    check("wrap_count", 32'(op_count), 32'h0);

    // Exhaustive operand sweep on requester 1
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) push(1, 4'(a), 4'(b));
    drain(256 * 3 + 20);

    // Random traffic, random consumer, valid jitter while busy
    rmode  = 2;
    jitter = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) push(0, 4'($urandom), 4'($urandom));
      if ($urandom_range(3, 0) == 0) push(1, 4'($urandom), 4'($urandom));
      if ($urandom_range(150, 0) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    rmode  = 1;
    jitter = 1'b0;
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
